layer_scheduler: RTL

Sequences a bank of P physical neuron units through every neuron of every layer of a feed-forward network. It time-multiplexes the bank across each layer in batches of P neurons, drives per-lane start pulses, collects completion, and signals the output buffer to store each batch. It also ping-pongs the activation buffers between layers. Sits above the neuron units and below the top-level network control.

---
 rtl/layer_scheduler.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/layer_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : layer_scheduler
// Description : Walks a bank of P neuron units across every neuron of every
//               layer of a feed-forward network. Each layer is processed in
//               batches of P neurons. For each batch the scheduler pulses the
//               enabled lanes, waits until every enabled lane reports finish,
//               and then requests a store of the batch outputs. The activation
//               buffer select toggles after each non-empty layer completes.
// Ports       : clk, rst                  - clock, async active-high reset
//               start, num_layers         - launch a run of num_layers layers
//               cfg_we, cfg_addr, cfg_size- layer size writes (IDLE only)
//               n_start / n_finish        - per-lane start pulse / ready level
//               lane_en                   - lanes holding a valid neuron
//               layer_idx, group_base     - current layer / lane-0 neuron index
//               buf_sel                   - activation ping-pong select
//               out_we, busy, done        - store strobe, run active, run end
// Revision    : 1.0 - initial release
// ============================================================================
module layer_scheduler #(
    parameter int P    = 4,
    parameter int MAXL = 4,
    parameter int LW   = 2,
    parameter int SW   = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [LW:0]   num_layers,
    input  logic          cfg_we,
    input  logic [LW-1:0] cfg_addr,
    input  logic [SW-1:0] cfg_size,
    output logic [P-1:0]  n_start,
    input  logic [P-1:0]  n_finish,
    output logic [P-1:0]  lane_en,
    output logic [LW:0]   layer_idx,
    output logic [SW-1:0] group_base,
    output logic          buf_sel,
    output logic          out_we,
    output logic          busy,
    output logic          done
);

    localparam logic [2:0] c_idle  = 3'd0;
    localparam logic [2:0] c_check = 3'd1;
    localparam logic [2:0] c_issue = 3'd2;
    localparam logic [2:0] c_guard = 3'd3;
    localparam logic [2:0] c_wait  = 3'd4;
    localparam logic [2:0] c_write = 3'd5;
    localparam logic [2:0] c_next  = 3'd6;
    localparam logic [2:0] c_done  = 3'd7;

    localparam logic [LW:0]   c_maxl  = (LW+1)'(MAXL);
    localparam logic [SW:0]   c_p_ext = (SW+1)'(P);
    localparam logic [SW-1:0] c_p_sw  = SW'(P);

    logic [2:0]    r_state;
    logic [2:0]    w_next;
    logic [SW-1:0] r_size [MAXL];
    logic [LW:0]   r_count;
    logic [LW:0]   r_layer;
    logic [SW-1:0] r_base;
    logic          r_buf;

    logic [SW-1:0] w_cur_size;
    logic          w_last_batch;
    logic          w_all_done;
    logic [LW:0]   w_clamped;

    // layer_idx reaches MAXL when a full-depth run ends; treat it as empty
    // rather than indexing past the register file.
    always_comb begin
        w_cur_size = '0;
        if (r_layer < c_maxl) begin
            w_cur_size = r_size[r_layer[LW-1:0]];
        end
    end

    // Extra MSB keeps base + P from wrapping near the top of the size range.
    assign w_last_batch = ({1'b0, r_base} + c_p_ext) >= {1'b0, w_cur_size};
    assign w_all_done   = &(n_finish | ~lane_en);
    assign w_clamped    = (num_layers > c_maxl) ? c_maxl : num_layers;

    for (genvar i = 0; i < P; i++) begin : g_lane
        assign lane_en[i] = (r_state != c_idle) &&
                            (({1'b0, r_base} + (SW+1)'(i)) < {1'b0, w_cur_size});
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_idle:  if (start) w_next = c_check;
            c_check: begin
                if (r_layer == r_count)    w_next = c_done;
                else if (w_cur_size == '0) w_next = c_check;
                else                       w_next = c_issue;
            end
            c_issue: w_next = c_guard;
            // Units may still show finish from their previous job this cycle.
            c_guard: w_next = c_wait;
            c_wait:  if (w_all_done) w_next = c_write;
            c_write: w_next = c_next;
            c_next:  w_next = c_check;
            c_done:  w_next = c_idle;
            default: w_next = c_idle;
        endcase
    end

    // Outputs decoded from registered state
    always_comb begin
        n_start = (r_state == c_issue) ? lane_en : '0;
        out_we  = (r_state == c_write);
        busy    = (r_state != c_idle);
        done    = (r_state == c_done);
    end

    // Datapath: size file, layer/batch counters, buffer select
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < MAXL; k++) begin
                r_size[k] <= '0;
            end
            r_count <= '0;
            r_layer <= '0;
            r_base  <= '0;
            r_buf   <= 1'b0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (cfg_we) begin
                        r_size[cfg_addr] <= cfg_size;
                    end
                    if (start) begin
                        r_count <= w_clamped;
                        r_layer <= '0;
                        r_base  <= '0;
                    end
                end
                c_check: begin
                    if ((r_layer != r_count) && (w_cur_size == '0)) begin
                        r_layer <= r_layer + 1'b1;
                    end
                end
                c_next: begin
                    if (w_last_batch) begin
                        r_layer <= r_layer + 1'b1;
                        r_base  <= '0;
                        r_buf   <= ~r_buf;
                    end else begin
                        r_base  <= r_base + c_p_sw;
                    end
                end
                default: ;
            endcase
        end
    end

    assign layer_idx  = r_layer;
    assign group_base = r_base;
    assign buf_sel    = r_buf;

endmodule
`default_nettype wire
